// File: rtl/softsw_pkg.sv
// Shared constants for the soft-switch status reporter: slot map, word fields, FSM encoding.
package softsw_pkg;

  localparam int unsigned SW_ROM_BANK      = 0;
  localparam int unsigned SW_TURBOFDC      = 1;
  localparam int unsigned SW_COVOX_EN      = 2;
  localparam int unsigned SW_PSG_MIX       = 3;
  localparam int unsigned SW_PSG_TYPE      = 4;
  localparam int unsigned SW_VIDEO_15KHZ   = 5;
  localparam int unsigned SW_VIDEO_60HZ    = 6;
  localparam int unsigned SW_TURBO         = 7;
  localparam int unsigned SW_SWAP_FDD      = 8;
  localparam int unsigned SW_JOY_TYPE      = 9;
  localparam int unsigned SW_VIDEO_MODE    = 10;
  localparam int unsigned SW_DIVMMC_EN     = 11;
  localparam int unsigned SW_NEMOIDE_EN    = 12;
  localparam int unsigned SW_KEYBOARD_TYPE = 13;
  localparam int unsigned SW_PAUSE         = 14;
  localparam int unsigned SW_NMI           = 15;
  localparam int unsigned SW_RESET         = 16;

  localparam int unsigned SW_ADDR_MSB = 15;
  localparam int unsigned SW_ADDR_LSB = 8;
  localparam int unsigned SW_DATA_MSB = 7;
  localparam int unsigned SW_DATA_LSB = 0;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/softsw_refresh_timer.sv
// Free-running 0..PERIOD-1 counter; wrap_o is high during the last count of each period.
module softsw_refresh_timer #(
  parameter int unsigned PERIOD = 2**20
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap_o
);
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  assign wrap_o = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt_q <= '0;
    else if (wrap_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/softsw_status_tx.sv
// Reports changed/forced soft-switch slots to the MCU as {slot, value} words over valid/ready.
// Define SOFTSW_TX_REFRESH_EN to add a periodic full dump every REFRESH_CYCLES clocks.
//
// state | meaning
// SCAN  | look at one slot per cycle, round-robin, for a dirty one
// SEND  | word held on tx_data/tx_valid until the sink takes it
module softsw_status_tx
  import softsw_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 17,
  parameter int unsigned SLOT_W         = 8,
  parameter int unsigned REFRESH_CYCLES = 2**20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SLOTS*SLOT_W-1:0] status_bus,
  input  logic                        resync_req,
  output logic [15:0]                 tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        idle
);
  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 256 || SLOT_W < 1 || SLOT_W > 8 || REFRESH_CYCLES < 1)
  begin : g_bad_param
    $error("softsw_status_tx: parameter out of range");
  end

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [15:0] make_word(input logic [PTR_W-1:0] s,
                                            input logic [SLOT_W-1:0] v);
    logic [15:0] w;
    w = '0;
    w[SW_ADDR_LSB +: PTR_W]  = s;
    w[SW_DATA_LSB +: SLOT_W] = v;
    return w;
  endfunction

  tx_state_e            state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     slot_q;
  logic [15:0]          tx_data_q;
  logic                 tx_valid_q;
  logic                 idle_q;
  logic [SLOT_W-1:0]    sent_q   [NUM_SLOTS];
  logic [SLOT_W-1:0]    status_a [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] force_q;
  logic [NUM_SLOTS-1:0] force_d;
  logic [NUM_SLOTS-1:0] dirty;
  logic                 xfer;
  logic                 refresh_wrap;

`ifdef SOFTSW_TX_REFRESH_EN
  softsw_refresh_timer #(
    .PERIOD (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrap_o (refresh_wrap)
  );
`else
  assign refresh_wrap = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      status_a[i] = status_bus[i*SLOT_W +: SLOT_W];
      dirty[i]    = (status_a[i] != sent_q[i]) | force_q[i];
    end
  end

  assign xfer = (state_q == ST_SEND) && tx_ready;

  // A full-dump request wins over the per-slot clear, so the word in flight is resent.
  always_comb begin
    force_d = force_q;
    if (xfer) force_d[slot_q] = 1'b0;
    if (resync_req || refresh_wrap) force_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SCAN;
      ptr_q      <= '0;
      slot_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      idle_q     <= 1'b0;
      force_q    <= '1;
      for (int i = 0; i < NUM_SLOTS; i++) sent_q[i] <= '0;
    end else begin
      force_q <= force_d;
      idle_q  <= (state_q == ST_SCAN) && !(|dirty);
      case (state_q)
        ST_SCAN: begin
          if (dirty[ptr_q]) begin
            tx_data_q  <= make_word(ptr_q, status_a[ptr_q]);
            tx_valid_q <= 1'b1;
            slot_q     <= ptr_q;
            state_q    <= ST_SEND;
          end else begin
            ptr_q <= next_slot(ptr_q);
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            // Record what actually went out; a newer value stays dirty.
            sent_q[slot_q] <= tx_data_q[SW_DATA_LSB +: SLOT_W];
            tx_valid_q     <= 1'b0;
            ptr_q          <= next_slot(slot_q);
            state_q        <= ST_SCAN;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign idle     = idle_q;

endmodule
